uart_tx_fsm: RTL and testbench
==============================

# uart_tx_fsm

Serial UART transmitter that sits directly upstream of the level-to-pulse stage on the transmit path. It takes a parallel word from the TX async FIFO read port, serialises it as start, data (LSB first), optional parity and stop bits, one bit per `CLK` cycle. It drives `BUSY` high for the full frame. The downstream pulse stage converts each rising edge of `BUSY` into a single FIFO read-increment pulse, so every accepted word must produce exactly one `BUSY` rising edge.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame (≥ 2).
- `CLK`  in  1: transmit bit clock, one serial bit per cycle.
- `RST`  in  1: reset, asynchronous, active-low.
- `P_DATA`  in  `DATA_WIDTH`: parallel word from the FIFO read data.
- `DATA_VALID`  in  1: word available (FIFO not empty); level, not pulse.
- `PAR_EN`  in  1: 1 = append a parity bit.
- `PAR_TYP`  in  1: 0 = even parity, 1 = odd parity.
- `TX_OUT`  out  1: serial line, registered, idles high.
- `BUSY`  out  1: registered; high from the start bit through the stop bit.

## Operation
- **States:** `IDLE`, `START`, `DATA`, `PARITY`, `STOP`.
- **`IDLE`:** `TX_OUT`=1, `BUSY`=0.
  - If `DATA_VALID`=1 at a rising edge, latch `P_DATA`, `PAR_EN` and `PAR_TYP` into internal registers, then go to `START`.
- **`START`:** `TX_OUT`=0 for one cycle, then go to `DATA`. Clear the bit counter.
- **`DATA`:** `TX_OUT` = latched bit[cnt], cnt = 0 … `DATA_WIDTH`-1, LSB first.
  - After bit `DATA_WIDTH`-1, go to `PARITY` if latched `PAR_EN`=1, otherwise go to `STOP`.
  - Bit counter width is $clog2(`DATA_WIDTH`). The counter does not wrap inside a frame.
- **`PARITY`:** `TX_OUT` = ^data when `PAR_TYP`=0, or ~^data when `PAR_TYP`=1, computed on the latched word. Lasts one cycle, then go to `STOP`.
- **`STOP`:** `TX_OUT`=1 for one cycle, then go unconditionally to `IDLE`.
- **Input sampling:**
  - `DATA_VALID`, `P_DATA`, `PAR_EN` and `PAR_TYP` are ignored in every state except `IDLE`.
  - Mid-frame changes to these inputs have no effect on the frame in progress.
- **Frame separation:** there is no `STOP`→`START` bypass.
  - At least one `IDLE` cycle with `BUSY`=0 separates frames.
  - This guarantees a distinct `BUSY` rising edge per word for the downstream pulse stage.
- **Reset:** `RST` low at any time asynchronously forces `IDLE`, `TX_OUT`=1, `BUSY`=0, and counter and latches to 0. A frame in progress is aborted and not resumed.

## Timing
- **Reset values:** `TX_OUT`=1, `BUSY`=0.
- **Acceptance latency:** let edge k be the edge where `IDLE` samples `DATA_VALID`=1. After edge k, `TX_OUT`=0 (start bit) and `BUSY`=1, so latency is one edge.
- **Data bits:** present after edges k+1 … k+`DATA_WIDTH`.
- **Parity bit (if enabled):** present after edge k+`DATA_WIDTH`+1.
- **Stop bit:** present after edge k+`DATA_WIDTH`+P+1, where P = `PAR_EN`.
- **Frame end:** after edge k+`DATA_WIDTH`+P+2, `BUSY`=0 and `TX_OUT`=1.
- **Frame length:** `BUSY` is high for exactly `DATA_WIDTH`+P+2 cycles.
- **Back-to-back frames:** with `DATA_VALID` held high, the earliest next acceptance is edge k+`DATA_WIDTH`+P+3. `BUSY` is low for exactly one cycle between frames.
- **Glitch-free outputs:** `TX_OUT` and `BUSY` are driven directly from flops, with no combinational path from inputs to outputs.

## Test plan
- **No parity:** `DATA_WIDTH`=8, `PAR_EN`=0, `P_DATA`=8'hA5, `DATA_VALID` pulsed in `IDLE`.
  - `TX_OUT` sequence: 0,1,0,1,0,0,1,0,1,1.
  - `BUSY` high for exactly 10 cycles, starting one edge after acceptance.
- **Parity on 8'hA5:**
  - `PAR_EN`=1, `PAR_TYP`=0: parity bit 0, `BUSY` high for 11 cycles.
  - `PAR_EN`=1, `PAR_TYP`=1: parity bit 1.
- **Parity on 8'h37** (five ones):
  - `PAR_TYP`=0: parity bit 1.
  - `PAR_TYP`=1: parity bit 0.
- **Back-to-back:** `DATA_VALID` held high, `P_DATA`=8'h01 then 8'hFE, `PAR_EN`=0.
  - Two frames are sent, with `BUSY`=0 for exactly one cycle between them.
  - Two `BUSY` rising edges are observed.
- **Input stability:** change `P_DATA`, `PAR_EN` and `PAR_TYP` during the `DATA` state.
  - The transmitted frame matches the values latched at acceptance.
  - No spurious frame follows when `DATA_VALID` drops.
- **Reset mid-frame:** assert `RST` low during data bit 3.
  - `TX_OUT`=1 and `BUSY`=0 immediately, with no clock required.
  - After release with `DATA_VALID`=1, a full fresh frame starts at the first edge.

Source files
------------

// File: rtl/uart_tx_fsm_if.sv
// Transmit-side bundle between the TX FIFO read port and the UART serialiser.
// The master supplies words; the slave (the transmitter) drives the line and BUSY.
interface uart_tx_fsm_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  BUSY;

  modport master (
    output P_DATA,
    output DATA_VALID,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  BUSY
  );

  modport slave (
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output BUSY
  );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART frame serialiser: start bit, DATA_WIDTH data bits LSB first, optional
// parity, stop bit, one bit per CLK. BUSY covers the whole frame and always
// drops for at least one IDLE cycle between frames so every accepted word
// gives the downstream pulse stage exactly one BUSY rising edge.
module uart_tx_fsm #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic              CLK,
  input  logic              RST,
  uart_tx_fsm_if.slave      tx
);

  localparam int unsigned CntWidth = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [CntWidth-1:0]   cnt_q;
  logic                  tx_out_q;
  logic                  busy_q;

  logic [CntWidth-1:0]   cnt_nxt;
  logic                  par_bit;

  assign cnt_nxt = cnt_q + CntWidth'(1);
  // Parity is taken from the latched word so mid-frame input changes cannot leak in.
  assign par_bit = par_typ_q ? ~^data_q : ^data_q;

  // Frame sequencer; outputs are loaded with the value of the state being entered.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= StIdle;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      cnt_q     <= '0;
      tx_out_q  <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          tx_out_q <= 1'b1;
          busy_q   <= 1'b0;
          if (tx.DATA_VALID) begin
            data_q    <= tx.P_DATA;
            par_en_q  <= tx.PAR_EN;
            par_typ_q <= tx.PAR_TYP;
            state_q   <= StStart;
            tx_out_q  <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StStart: begin
          cnt_q    <= '0;
          state_q  <= StData;
          tx_out_q <= data_q[0];
        end
        StData: begin
          if (cnt_q == CntLast) begin
            if (par_en_q) begin
              state_q  <= StParity;
              tx_out_q <= par_bit;
            end else begin
              state_q  <= StStop;
              tx_out_q <= 1'b1;
            end
          end else begin
            cnt_q    <= cnt_nxt;
            tx_out_q <= data_q[cnt_nxt];
          end
        end
        StParity: begin
          state_q  <= StStop;
          tx_out_q <= 1'b1;
        end
        StStop: begin
          // Always pass through IDLE so BUSY is low for at least one cycle.
          state_q  <= StIdle;
          tx_out_q <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q  <= StIdle;
          tx_out_q <= 1'b1;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign tx.TX_OUT = tx_out_q;
  assign tx.BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm with hand-computed serial frames.
module tb_uart_tx_fsm;
  localparam int unsigned DW = 8;

  logic CLK;
  logic RST;
  int   n_tests;
  int   n_fail;

  uart_tx_fsm_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_fsm #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .tx  (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one rising edge and sample 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.DATA_VALID = 1'b0;
    bus.P_DATA = '0;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    #2 RST = 1'b0;
    #1;
    n_tests++;
    if (bus.TX_OUT !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_tx: TX_OUT=%b required 1", bus.TX_OUT);
    end
    n_tests++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: BUSY=%b required 0", bus.BUSY);
    end
    // DATA_VALID must not start a frame while reset is held.
    bus.DATA_VALID = 1'b1;
    step();
    step();
    n_tests++;
    if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: TX_OUT=%b BUSY=%b required 1/0", bus.TX_OUT, bus.BUSY);
    end
    bus.DATA_VALID = 1'b0;
    RST = 1'b1;
    step();
    n_tests++;
    if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: TX_OUT=%b BUSY=%b required 1/0", bus.TX_OUT, bus.BUSY);
    end
  endtask

  task automatic test_no_parity();
    logic [0:9] exp_tx;
    exp_tx = 10'b0101001011;
    n_tests++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL no_parity_pre: BUSY=%b required 0", bus.BUSY);
    end
    bus.P_DATA = 8'hA5;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.DATA_VALID = 1'b1;
    step();
    bus.DATA_VALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      n_tests++;
      if (bus.TX_OUT !== exp_tx[i] || bus.BUSY !== 1'b1) begin
        n_fail++;
        $display("FAIL no_parity_bit%0d: TX_OUT=%b BUSY=%b required %b/1",
                 i, bus.TX_OUT, bus.BUSY, exp_tx[i]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL no_parity_end%0d: TX_OUT=%b BUSY=%b required 1/0",
                 i, bus.TX_OUT, bus.BUSY);
      end
    end
  endtask

  task automatic test_parity();
    logic [7:0]  case_data [4];
    logic        case_typ  [4];
    logic        case_par  [4];
    logic [0:10] exp_tx;
    logic [7:0]  d;
    case_data[0] = 8'hA5; case_typ[0] = 1'b0; case_par[0] = 1'b0;
    case_data[1] = 8'hA5; case_typ[1] = 1'b1; case_par[1] = 1'b1;
    case_data[2] = 8'h37; case_typ[2] = 1'b0; case_par[2] = 1'b1;
    case_data[3] = 8'h37; case_typ[3] = 1'b1; case_par[3] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      d = case_data[c];
      exp_tx[0] = 1'b0;
      for (int b = 0; b < 8; b++) exp_tx[b+1] = d[b];
      exp_tx[9]  = case_par[c];
      exp_tx[10] = 1'b1;
      bus.P_DATA = d;
      bus.PAR_EN = 1'b1;
      bus.PAR_TYP = case_typ[c];
      bus.DATA_VALID = 1'b1;
      step();
      bus.DATA_VALID = 1'b0;
      for (int i = 0; i < 11; i++) begin
        if (i > 0) step();
        n_tests++;
        if (bus.TX_OUT !== exp_tx[i] || bus.BUSY !== 1'b1) begin
          n_fail++;
          $display("FAIL parity_case%0d_bit%0d: TX_OUT=%b BUSY=%b required %b/1",
                   c, i, bus.TX_OUT, bus.BUSY, exp_tx[i]);
        end
      end
      step();
      n_tests++;
      if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL parity_case%0d_end: TX_OUT=%b BUSY=%b required 1/0",
                 c, bus.TX_OUT, bus.BUSY);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [0:21] exp_tx;
    logic [0:21] exp_busy;
    logic        prev_busy;
    int          rises;
    exp_tx   = 22'b0100000001_1_0011111111_1;
    exp_busy = 22'b1111111111_0_1111111111_0;
    prev_busy = bus.BUSY;
    rises = 0;
    bus.P_DATA = 8'h01;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.DATA_VALID = 1'b1;
    for (int i = 0; i < 22; i++) begin
      step();
      // Next word is presented as soon as the first one has been taken.
      if (i == 0) bus.P_DATA = 8'hFE;
      if (i == 11) bus.DATA_VALID = 1'b0;
      if (bus.BUSY === 1'b1 && prev_busy === 1'b0) rises++;
      prev_busy = bus.BUSY;
      n_tests++;
      if (bus.TX_OUT !== exp_tx[i] || bus.BUSY !== exp_busy[i]) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: TX_OUT=%b BUSY=%b required %b/%b",
                 i, bus.TX_OUT, bus.BUSY, exp_tx[i], exp_busy[i]);
      end
    end
    step();
    n_tests++;
    if (bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_tail: BUSY=%b required 0", bus.BUSY);
    end
    n_tests++;
    if (rises !== 2) begin
      n_fail++;
      $display("FAIL b2b_rises: rising edges=%0d required 2", rises);
    end
  endtask

  task automatic test_input_stability();
    logic [0:10] exp_tx;
    // A5, even parity latched at acceptance: parity 0.
    exp_tx = 11'b0_10100101_0_1;
    bus.P_DATA = 8'hA5;
    bus.PAR_EN = 1'b1;
    bus.PAR_TYP = 1'b0;
    bus.DATA_VALID = 1'b1;
    step();
    bus.DATA_VALID = 1'b0;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) step();
      if (i == 2) begin
        bus.P_DATA = 8'h00;
        bus.PAR_EN = 1'b0;
        bus.PAR_TYP = 1'b1;
        bus.DATA_VALID = 1'b1;
      end
      if (i == 10) bus.DATA_VALID = 1'b0;
      n_tests++;
      if (bus.TX_OUT !== exp_tx[i] || bus.BUSY !== 1'b1) begin
        n_fail++;
        $display("FAIL stable_bit%0d: TX_OUT=%b BUSY=%b required %b/1",
                 i, bus.TX_OUT, bus.BUSY, exp_tx[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++;
      if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL stable_idle%0d: TX_OUT=%b BUSY=%b required 1/0",
                 i, bus.TX_OUT, bus.BUSY);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [0:9] exp_tx;
    // 37 with no parity: start, 1,1,1,0,1,1,0,0, stop.
    exp_tx = 10'b0111011001;
    bus.P_DATA = 8'hA5;
    bus.PAR_EN = 1'b0;
    bus.PAR_TYP = 1'b0;
    bus.DATA_VALID = 1'b1;
    step();
    bus.DATA_VALID = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_tests++;
    if (bus.TX_OUT !== 1'b0 || bus.BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_bit3: TX_OUT=%b BUSY=%b required 0/1", bus.TX_OUT, bus.BUSY);
    end
    #2 RST = 1'b0;
    #1;
    n_tests++;
    if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: TX_OUT=%b BUSY=%b required 1/0", bus.TX_OUT, bus.BUSY);
    end
    bus.P_DATA = 8'h37;
    bus.DATA_VALID = 1'b1;
    RST = 1'b1;
    step();
    bus.DATA_VALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      n_tests++;
      if (bus.TX_OUT !== exp_tx[i] || bus.BUSY !== 1'b1) begin
        n_fail++;
        $display("FAIL rst_fresh_bit%0d: TX_OUT=%b BUSY=%b required %b/1",
                 i, bus.TX_OUT, bus.BUSY, exp_tx[i]);
      end
    end
    step();
    n_tests++;
    if (bus.TX_OUT !== 1'b1 || bus.BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_fresh_end: TX_OUT=%b BUSY=%b required 1/0", bus.TX_OUT, bus.BUSY);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    test_reset();
    test_no_parity();
    test_parity();
    test_back_to_back();
    test_input_stability();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
